// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access stage: FSM encoding, R_W/DATA_SIZE
// meanings and the byte-lane helpers used by the controller and the MDR.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_e;

  localparam logic R_W_READ  = 1'b0;
  localparam logic R_W_WRITE = 1'b1;
  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  // Byte enables {hi,lo}; a byte access picks the lane addressed by bit 0.
  function automatic logic [1:0] byte_enables(input logic size, input logic addr_lsb);
    logic [1:0] be;
    case ({size, addr_lsb})
      2'b00:   be = 2'b01;
      2'b01:   be = 2'b10;
      2'b10:   be = 2'b11;
      2'b11:   be = 2'b11;
      default: be = 2'b00;
    endcase
    return be;
  endfunction

  // Byte stores read MDR on either lane, so the low bus byte is copied to both.
  function automatic logic [15:0] bus_to_mdr(input logic size, input logic [15:0] bus);
    logic [15:0] val;
    if (size == SIZE_WORD) begin
      val = bus;
    end else begin
      val = {bus[7:0], bus[7:0]};
    end
    return val;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/acknowledge memory port between the access controller (master)
// and the memory (slave).
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_ctrl_mdr_reg.sv
// Memory data register: loads read data during a memory cycle, otherwise
// from the datapath bus with byte replication for byte-sized loads.
module mdr_reg
  import mem_access_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_bus_i,
  input  logic        ld_mem_i,
  input  logic        bus_size_i,
  input  logic [15:0] bus_in_i,
  input  logic [15:0] mem_rdata_i,
  output logic [15:0] mdr_o
);

  logic [15:0] mdr_d;
  logic [15:0] mdr_q;

  always_comb begin
    mdr_d = mdr_q;
    if (ld_mem_i) begin
      mdr_d = mem_rdata_i;
    end else if (ld_bus_i) begin
      mdr_d = bus_to_mdr(bus_size_i, bus_in_i);
    end else begin
      mdr_d = mdr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdr_q <= 16'h0000;
    end else begin
      mdr_q <= mdr_d;
    end
  end

  assign mdr_o = mdr_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access stage: sequences one read or write per control-store memory
// state over a req/ack port, owns MDR and reports completion with R.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] MAR,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              LD_MDR,
  input  logic              MIO_EN,
  input  logic              R_W,
  input  logic              DATA_SIZE,
  output logic [DATA_W-1:0] MDR,
  output logic              R,
  output logic              err,
  output logic              unaligned,
  mem_access_ctrl_if.master mem
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TO_EN = (TIMEOUT != 0);

  state_e            state_q;
  logic              req_q;
  logic              we_q;
  logic [1:0]        be_q;
  logic [ADDR_W-1:0] addr_q;
  logic              r_q;
  logic              err_q;
  logic              unal_q;
  logic [CNT_W-1:0]  cnt_q;

  logic timeout_hit_s;
  logic ld_mem_s;
  logic ld_bus_s;

  // The counter reaching TIMEOUT at the end of this cycle aborts the access.
  assign timeout_hit_s = TO_EN && (cnt_q == CNT_LAST);
  assign ld_mem_s = (state_q == ST_ACCESS) && mem.mem_ack && (we_q == R_W_READ);
  assign ld_bus_s = (state_q == ST_IDLE) && !MIO_EN && LD_MDR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 2'b00;
      addr_q  <= {ADDR_W{1'b0}};
      r_q     <= 1'b0;
      err_q   <= 1'b0;
      unal_q  <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      r_q    <= 1'b0;
      err_q  <= 1'b0;
      unal_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (MIO_EN) begin
            state_q <= ST_ACCESS;
            req_q   <= 1'b1;
            we_q    <= R_W;
            be_q    <= byte_enables(DATA_SIZE, MAR[0]);
            addr_q  <= {MAR[ADDR_W-1:1], 1'b0};
            unal_q  <= (DATA_SIZE == SIZE_WORD) && MAR[0];
            cnt_q   <= {CNT_W{1'b0}};
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          // An ack arriving with the timeout still completes normally.
          if (mem.mem_ack) begin
            state_q <= ST_DONE;
            req_q   <= 1'b0;
            r_q     <= 1'b1;
          end else if (timeout_hit_s) begin
            state_q <= ST_DONE;
            req_q   <= 1'b0;
            r_q     <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            state_q <= ST_ACCESS;
          end
          if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            cnt_q <= cnt_q;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  mdr_reg u_mdr (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_bus_i    (ld_bus_s),
    .ld_mem_i    (ld_mem_s),
    .bus_size_i  (DATA_SIZE),
    .bus_in_i    (bus_in[15:0]),
    .mem_rdata_i (mem.mem_rdata),
    .mdr_o       (MDR)
  );

  assign R             = r_q;
  assign err           = err_q;
  assign unaligned     = unal_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = MDR;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a table of complete accesses plus
// hand-written back-to-back and reset-during-access sequences.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] mar;
  logic [15:0] bus_in;
  logic        ld_mdr;
  logic        mio_en;
  logic        r_w;
  logic        data_size;
  logic [15:0] mdr;
  logic        r;
  logic        err;
  logic        unaligned;

  int n_vec;
  int n_bad;

  mem_access_ctrl_if #(.ADDR_W(16)) mem_bus ();

  mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .MAR       (mar),
    .bus_in    (bus_in),
    .LD_MDR    (ld_mdr),
    .MIO_EN    (mio_en),
    .R_W       (r_w),
    .DATA_SIZE (data_size),
    .MDR       (mdr),
    .R         (r),
    .err       (err),
    .unaligned (unaligned),
    .mem       (mem_bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        do_ld;
    logic        ld_size;
    logic [15:0] bus;
    logic [15:0] mar;
    logic        rw;
    logic        size;
    int          ack_at;
    logic [15:0] rdata;
    logic [1:0]  exp_be;
    logic [15:0] exp_addr;
    logic        exp_unal;
    logic [15:0] exp_pre;
    logic [15:0] exp_mdr;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    if (v.do_ld) begin
      ld_mdr    = 1'b1;
      data_size = v.ld_size;
      bus_in    = v.bus;
      @(negedge clk);
      ld_mdr = 1'b0;
      chk($sformatf("v%0d_bus_load", idx), {16'h0, mdr}, {16'h0, v.exp_pre});
    end
    mar       = v.mar;
    r_w       = v.rw;
    data_size = v.size;
    mio_en    = 1'b1;
    @(negedge clk);
    n = 1;
    chk($sformatf("v%0d_req", idx), {31'h0, mem_bus.mem_req}, 32'h1);
    chk($sformatf("v%0d_be", idx), {30'h0, mem_bus.mem_be}, {30'h0, v.exp_be});
    chk($sformatf("v%0d_addr", idx), {16'h0, mem_bus.mem_addr}, {16'h0, v.exp_addr});
    chk($sformatf("v%0d_we", idx), {31'h0, mem_bus.mem_we}, {31'h0, v.rw});
    chk($sformatf("v%0d_unal", idx), {31'h0, unaligned}, {31'h0, v.exp_unal});
    chk($sformatf("v%0d_wdata", idx), {16'h0, mem_bus.mem_wdata}, {16'h0, v.exp_pre});
    // Scramble the inputs: the latched request must not follow them.
    mar       = ~v.mar;
    r_w       = ~v.rw;
    data_size = ~v.size;
    while (!r && n < 40) begin
      mem_bus.mem_ack   = (n == v.ack_at);
      mem_bus.mem_rdata = v.rdata;
      @(negedge clk);
      mem_bus.mem_ack = 1'b0;
      n++;
      if (!r) begin
        chk($sformatf("v%0d_req_held", idx), {31'h0, mem_bus.mem_req}, 32'h1);
        chk($sformatf("v%0d_addr_held", idx), {16'h0, mem_bus.mem_addr}, {16'h0, v.exp_addr});
        chk($sformatf("v%0d_unal_pulse", idx), {31'h0, unaligned}, 32'h0);
      end
    end
    chk($sformatf("v%0d_R", idx), {31'h0, r}, 32'h1);
    chk($sformatf("v%0d_latency", idx), n + 1, v.exp_lat);
    chk($sformatf("v%0d_err", idx), {31'h0, err}, {31'h0, v.exp_err});
    chk($sformatf("v%0d_mdr", idx), {16'h0, mdr}, {16'h0, v.exp_mdr});
    chk($sformatf("v%0d_req_drop", idx), {31'h0, mem_bus.mem_req}, 32'h0);
    mio_en = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_R_pulse", idx), {31'h0, r}, 32'h0);
    chk($sformatf("v%0d_err_pulse", idx), {31'h0, err}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    //            ld    lsz   bus       mar       rw    sz    ack rdata     be     addr      unal  pre       mdr       err   lat
    vecs[0] = '{1'b0, 1'b0, 16'h0000, 16'h3000, 1'b0, 1'b1, 2, 16'hBEEF, 2'b11, 16'h3000, 1'b0, 16'h0000, 16'hBEEF, 1'b0, 4};
    vecs[1] = '{1'b1, 1'b0, 16'h12AB, 16'h4001, 1'b1, 1'b0, 1, 16'h5555, 2'b10, 16'h4000, 1'b0, 16'hABAB, 16'hABAB, 1'b0, 3};
    vecs[2] = '{1'b0, 1'b0, 16'h0000, 16'h5003, 1'b0, 1'b1, 3, 16'h1234, 2'b11, 16'h5002, 1'b1, 16'hABAB, 16'h1234, 1'b0, 5};
    vecs[3] = '{1'b0, 1'b0, 16'h0000, 16'h6000, 1'b0, 1'b0, 1, 16'hCAFE, 2'b01, 16'h6000, 1'b0, 16'h1234, 16'hCAFE, 1'b0, 3};
    vecs[4] = '{1'b1, 1'b1, 16'h7777, 16'h7000, 1'b0, 1'b1, 0, 16'h9999, 2'b11, 16'h7000, 1'b0, 16'h7777, 16'h7777, 1'b1, 6};
    vecs[5] = '{1'b0, 1'b0, 16'h0000, 16'h8000, 1'b0, 1'b1, 4, 16'hA5A5, 2'b11, 16'h8000, 1'b0, 16'h7777, 16'hA5A5, 1'b0, 6};
    vecs[6] = '{1'b1, 1'b1, 16'h1357, 16'h9002, 1'b1, 1'b1, 2, 16'h2468, 2'b11, 16'h9002, 1'b0, 16'h1357, 16'h1357, 1'b0, 4};

    rst_n             = 1'b0;
    mar               = 16'h0000;
    bus_in            = 16'h0000;
    ld_mdr            = 1'b0;
    mio_en            = 1'b0;
    r_w               = 1'b0;
    data_size         = 1'b0;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_mdr", {16'h0, mdr}, 32'h0);
    chk("rst_outs", {28'h0, r, err, unaligned, mem_bus.mem_req}, 32'h0);
    chk("rst_port", {13'h0, mem_bus.mem_we, mem_bus.mem_be, mem_bus.mem_addr}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_vec(i, vecs[i]);
    end

    // Back-to-back: MIO_EN stays high through R, LD_MDR asserted throughout.
    mar       = 16'hB000;
    r_w       = 1'b0;
    data_size = 1'b1;
    mio_en    = 1'b1;
    @(negedge clk);
    ld_mdr            = 1'b1;
    bus_in            = 16'hFFFF;
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 16'h1111;
    @(negedge clk);
    mem_bus.mem_ack = 1'b0;
    chk("b2b_R1", {31'h0, r}, 32'h1);
    chk("b2b_mdr1", {16'h0, mdr}, 32'h1111);
    mar = 16'hC002;
    @(negedge clk);
    chk("b2b_idle_R", {31'h0, r}, 32'h0);
    chk("b2b_idle_req", {31'h0, mem_bus.mem_req}, 32'h0);
    chk("b2b_idle_mdr", {16'h0, mdr}, 32'h1111);
    @(negedge clk);
    chk("b2b_req2", {31'h0, mem_bus.mem_req}, 32'h1);
    chk("b2b_addr2", {16'h0, mem_bus.mem_addr}, 32'hC002);
    chk("b2b_mdr_hold", {16'h0, mdr}, 32'h1111);
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 16'h2222;
    @(negedge clk);
    mem_bus.mem_ack = 1'b0;
    chk("b2b_R2", {31'h0, r}, 32'h1);
    chk("b2b_mdr2", {16'h0, mdr}, 32'h2222);
    mio_en = 1'b0;
    ld_mdr = 1'b0;
    @(negedge clk);

    // Reset in the middle of an access, then a stray ack afterwards.
    mar       = 16'hA000;
    r_w       = 1'b0;
    data_size = 1'b1;
    mio_en    = 1'b1;
    @(negedge clk);
    chk("rma_req", {31'h0, mem_bus.mem_req}, 32'h1);
    #2;
    rst_n  = 1'b0;
    mio_en = 1'b0;
    #1;
    chk("rma_req_drop", {31'h0, mem_bus.mem_req}, 32'h0);
    chk("rma_mdr_clr", {16'h0, mdr}, 32'h0);
    @(negedge clk);
    rst_n             = 1'b1;
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 16'hFFFF;
    @(negedge clk);
    mem_bus.mem_ack = 1'b0;
    chk("rma_late_R", {31'h0, r}, 32'h0);
    chk("rma_late_mdr", {16'h0, mdr}, 32'h0);
    chk("rma_late_req", {31'h0, mem_bus.mem_req}, 32'h0);
    @(negedge clk);
    chk("rma_late_R2", {31'h0, r}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
